// File: rtl/pc_gen_pkg.sv
// Shared definitions for the pc_gen fetch-address generator: reset/increment
// defaults, control-level constants and the update-priority select enum.
package pc_gen_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0004;
    localparam int          INSTR_BYTES_DEF  = 4;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Branch      = 1'b1;
    localparam logic NoStop      = 1'b0;

    // Which update rule won at the current edge, highest priority first.
    typedef enum logic [2:0] {
        SEL_START,
        SEL_FLUSH,
        SEL_BRANCH,
        SEL_PEND_SET,
        SEL_PEND_TAKE,
        SEL_RAS_POP,
        SEL_SEQ,
        SEL_HOLD
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack for pc_gen (built only with PC_RAS_EN).
// When full, a push overwrites the oldest entry and the count saturates.
module pc_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [ADDR_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [ADDR_W-1:0]          top_o,
    output logic [$clog2(RAS_DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_addr;

    // wr_ptr points at the next free slot; the top lives one below it.
    assign top_ptr = wr_ptr_q - PTR_W'(1);
    assign top_o   = mem_q[top_ptr];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_en    = 1'b0;
        wr_addr  = wr_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (push_i && pop_i && (count_q != '0)) begin
            wr_en   = 1'b1;
            wr_addr = top_ptr;
        end else if (push_i) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (count_q != FULL) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_i && (count_q != '0)) begin
            wr_ptr_d = top_ptr;
            count_d  = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// IF-stage fetch-address generator with a held branch redirect across stalls.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
    parameter int                INSTR_BYTES  = INSTR_BYTES_DEF,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic [ADDR_W-1:0]          new_pc_i,
    input  logic                       branch_flag_i,
    input  logic [ADDR_W-1:0]          branch_target_i,
    input  logic                       ras_push_i,
    input  logic                       ras_pop_i,
    output logic [ADDR_W-1:0]          pc_o,
    output logic                       ce_o,
    output logic                       redirect_pending_o,
    output logic [$clog2(RAS_DEPTH):0] ras_count_o
);

    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic              ce_q, ce_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    pc_sel_e           sel;
    logic              advance;
    logic [ADDR_W-1:0] seq_pc;
    logic              ras_pop_ok;
    logic [ADDR_W-1:0] ras_top;
    logic [CNT_W-1:0]  ras_count;

    assign seq_pc  = pc_q + ADDR_W'(INSTR_BYTES);
    assign advance = (ce_q == ChipEnable) && !flush_i && (stall_i == NoStop);

`ifdef PC_RAS_EN
    logic [ADDR_W-1:0] link_pc;
    logic              ras_push_ok;

    // Link skips the delay slot.
    assign link_pc     = pc_q + ADDR_W'(2 * INSTR_BYTES);
    assign ras_push_ok = advance && ras_push_i;
    assign ras_pop_ok  = advance && ras_pop_i && (branch_flag_i != Branch) &&
                         !pend_q && (ras_count != '0);

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .clear_i     ((ce_q == ChipEnable) && flush_i),
        .push_i      (ras_push_ok),
        .push_data_i (link_pc),
        .pop_i       (ras_pop_ok),
        .top_o       (ras_top),
        .count_o     (ras_count)
    );
`else
    logic unused_ras_hints;

    assign unused_ras_hints = ras_push_i ^ ras_pop_i;
    assign ras_pop_ok       = 1'b0;
    assign ras_top          = '0;
    assign ras_count        = '0;
`endif

    always_comb begin
        sel = SEL_HOLD;
        if (ce_q == ChipDisable) begin
            sel = SEL_START;
        end else if (flush_i) begin
            sel = SEL_FLUSH;
        end else if ((branch_flag_i == Branch) && (stall_i == NoStop)) begin
            sel = SEL_BRANCH;
        end else if (branch_flag_i == Branch) begin
            sel = SEL_PEND_SET;
        end else if (pend_q && (stall_i == NoStop)) begin
            sel = SEL_PEND_TAKE;
        end else if (ras_pop_ok) begin
            sel = SEL_RAS_POP;
        end else if (stall_i == NoStop) begin
            sel = SEL_SEQ;
        end
    end

    always_comb begin
        ce_d       = ChipEnable;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        case (sel)
            SEL_START: pc_d = RESET_VECTOR;
            SEL_FLUSH: begin
                pc_d   = new_pc_i;
                pend_d = 1'b0;
            end
            SEL_BRANCH: begin
                pc_d   = branch_target_i;
                pend_d = 1'b0;
            end
            SEL_PEND_SET: begin
                pend_d     = 1'b1;
                pend_tgt_d = branch_target_i;
            end
            SEL_PEND_TAKE: begin
                pc_d   = pend_tgt_q;
                pend_d = 1'b0;
            end
            SEL_RAS_POP: pc_d = ras_top;
            SEL_SEQ:     pc_d = seq_pc;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            ce_q       <= ChipDisable;
            pc_q       <= RESET_VECTOR;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            ce_q       <= ce_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc_o               = pc_q;
    assign ce_o               = ce_q;
    assign redirect_pending_o = pend_q;
    assign ras_count_o        = ras_count;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pc_gen;

    localparam int ADDR_W    = 32;
    localparam int RAS_DEPTH = 4;
    localparam int CNT_W     = $clog2(RAS_DEPTH) + 1;
    localparam logic [31:0] RV = 32'h0000_0004;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall_i, flush_i, branch_flag_i, ras_push_i, ras_pop_i;
    logic [ADDR_W-1:0] new_pc_i, branch_target_i;
    logic [ADDR_W-1:0] pc_o;
    logic              ce_o, redirect_pending_o;
    logic [CNT_W-1:0]  ras_count_o;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .stall_i            (stall_i),
        .flush_i            (flush_i),
        .new_pc_i           (new_pc_i),
        .branch_flag_i      (branch_flag_i),
        .branch_target_i    (branch_target_i),
        .ras_push_i         (ras_push_i),
        .ras_pop_i          (ras_pop_i),
        .pc_o               (pc_o),
        .ce_o               (ce_o),
        .redirect_pending_o (redirect_pending_o),
        .ras_count_o        (ras_count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: architectural state plus the return stack as a queue.
    bit          m_init = 1'b0;
    bit          m_ce;
    logic [31:0] m_pc, m_tgt;
    bit          m_pend;
    logic [31:0] m_ras[$];

    always @(posedge clk) begin : model
        logic [31:0] nxt;
        bit adv;
        if (rst) begin
            m_init = 1'b1;
            m_ce   = 1'b0;
            m_pc   = RV;
            m_pend = 1'b0;
            m_tgt  = '0;
            m_ras.delete();
        end else if (m_init && !m_ce) begin
            m_ce = 1'b1;
            m_pc = RV;
        end else if (m_init) begin
            adv = !flush_i && !stall_i;
            nxt = m_pc;
            if (flush_i) begin
                nxt    = new_pc_i;
                m_pend = 1'b0;
                m_ras.delete();
            end else if (branch_flag_i && !stall_i) begin
                nxt    = branch_target_i;
                m_pend = 1'b0;
            end else if (branch_flag_i) begin
                m_pend = 1'b1;
                m_tgt  = branch_target_i;
            end else if (m_pend && !stall_i) begin
                nxt    = m_tgt;
                m_pend = 1'b0;
            end else if (!stall_i) begin
                nxt = m_pc + 32'd4;
`ifdef PC_RAS_EN
                if (ras_pop_i && m_ras.size() > 0) nxt = m_ras.pop_back();
`endif
            end
`ifdef PC_RAS_EN
            if (adv && ras_push_i) begin
                m_ras.push_back(m_pc + 32'd8);
                if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            end
`else
            adv = adv;
`endif
            m_pc = nxt;
        end
    end

    function automatic logic [31:0] exp_count();
`ifdef PC_RAS_EN
        return 32'(m_ras.size());
`else
        return 32'd0;
`endif
    endfunction

    // Compare process: every cycle once the model has seen a reset edge.
    always @(negedge clk) begin
        if (m_init) begin
            chk("model_ce", {31'd0, ce_o}, {31'd0, m_ce});
            chk("model_pc", pc_o, m_pc);
            chk("model_pending", {31'd0, redirect_pending_o}, {31'd0, m_pend});
            chk("model_ras_count", 32'(ras_count_o), exp_count());
        end
    end

    task automatic step(input bit st, input bit fl, input bit br,
                        input logic [31:0] np, input logic [31:0] bt,
                        input bit pu, input bit po);
        stall_i         = st;
        flush_i         = fl;
        branch_flag_i   = br;
        new_pc_i        = np;
        branch_target_i = bt;
        ras_push_i      = pu;
        ras_pop_i       = po;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        stall_i = 1'b0; flush_i = 1'b0; branch_flag_i = 1'b0;
        new_pc_i = '0; branch_target_i = '0; ras_push_i = 1'b0; ras_pop_i = 1'b0;

        // Reset release and first fetches
        repeat (3) idle();
        chk("reset_ce", {31'd0, ce_o}, 32'd0);
        chk("reset_pc", pc_o, 32'h4);
        chk("reset_count", 32'(ras_count_o), 32'd0);
        rst = 1'b0;
        idle();
        chk("first_ce", {31'd0, ce_o}, 32'd1);
        chk("first_pc", pc_o, 32'h4);
        idle();
        chk("second_pc", pc_o, 32'h8);
        idle();
        chk("third_pc", pc_o, 32'hC);

        // Branch during stall is held, then taken
        step(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
        chk("flush_to_100", pc_o, 32'h100);
        step(1'b1, 1'b0, 1'b1, 32'h0, 32'h400, 1'b0, 1'b0);
        chk("stall_branch_pc", pc_o, 32'h100);
        chk("stall_branch_pend", {31'd0, redirect_pending_o}, 32'd1);
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("stall_hold_pc", pc_o, 32'h100);
        chk("stall_hold_pend", {31'd0, redirect_pending_o}, 32'd1);
        idle();
        chk("pend_taken_pc", pc_o, 32'h400);
        chk("pend_taken_clear", {31'd0, redirect_pending_o}, 32'd0);
        idle();
        chk("after_pend_pc", pc_o, 32'h404);

        // Flush beats stall, branch and pending
        step(1'b1, 1'b0, 1'b1, 32'h0, 32'h500, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h180, 32'h400, 1'b0, 1'b0);
        chk("flush_pc", pc_o, 32'h180);
        chk("flush_pend", {31'd0, redirect_pending_o}, 32'd0);

        // Wrap-around
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        chk("pre_wrap_pc", pc_o, 32'hFFFF_FFFC);
        idle();
        chk("wrap_pc", pc_o, 32'h0);

        // Pop with an empty stack just increments (both builds)
        step(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("pop_empty_pc", pc_o, 32'h304);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef PC_RAS_EN
        chk("push_count", 32'(ras_count_o), 32'd1);
`else
        chk("push_ignored_count", 32'(ras_count_o), 32'd0);
`endif

`ifdef PC_RAS_EN
        // Return stack fill, overflow and pop
        step(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("ras_first_push_count", 32'(ras_count_o), 32'd1);
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("ras_full_count", 32'(ras_count_o), 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("ras_pop_pc", pc_o, 32'h21C);
        chk("ras_pop_count", 32'(ras_count_o), 32'd3);
`endif

        // Reset while a redirect is pending
        step(1'b1, 1'b0, 1'b1, 32'h0, 32'h400, 1'b0, 1'b0);
        chk("pre_reset_pend", {31'd0, redirect_pending_o}, 32'd1);
        rst = 1'b1;
        idle();
        chk("mid_reset_pc", pc_o, 32'h4);
        chk("mid_reset_pend", {31'd0, redirect_pending_o}, 32'd0);
        chk("mid_reset_count", 32'(ras_count_o), 32'd0);
        rst = 1'b0;
        idle();
        chk("post_reset_pc", pc_o, 32'h4);
        idle();
        chk("post_reset_no_redirect", pc_o, 32'h8);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 20, $urandom(), $urandom(),
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25);
        end
        rst = 1'b0;
        idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
